// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - BIST sweep driver/checker for a 2-input combinational gate
// Walks {in1,in2} through 00..11, samples out after SETTLE clocks per vector, compares to EXPECT.
module gate_truth_checker #(
  parameter logic [3:0] EXPECT = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] fail_mask,
  output logic [2:0] err_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(SETTLE - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [7:0] wait_q;
  logic [1:0] vec_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] result_q;
  logic [3:0] fail_mask_q;
  logic [2:0] err_cnt_q;

  logic       mis_d;
  logic [2:0] err_cnt_d;

  // Mismatch and running error count for the vector being sampled this edge.
  assign mis_d     = out ^ EXPECT[idx_q];
  assign err_cnt_d = err_cnt_q + {2'b00, mis_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      wait_q      <= 8'd0;
      vec_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      result_q    <= 4'd0;
      fail_mask_q <= 4'd0;
      err_cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (abort) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
          end else if (start) begin
            state_q     <= RUN;
            idx_q       <= 2'd0;
            wait_q      <= 8'd0;
            vec_q       <= 2'd0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            result_q    <= 4'd0;
            fail_mask_q <= 4'd0;
            err_cnt_q   <= 3'd0;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial result/fail_mask/err_cnt are intentionally kept for inspection.
            state_q <= IDLE;
            idx_q   <= 2'd0;
            wait_q  <= 8'd0;
            vec_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (wait_q != LAST_WAIT) begin
            wait_q <= wait_q + 8'd1;
            vec_q  <= idx_q;
          end else begin
            result_q[idx_q]    <= out;
            fail_mask_q[idx_q] <= mis_d;
            err_cnt_q          <= err_cnt_d;
            wait_q             <= 8'd0;
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
              vec_q <= idx_q + 2'd1;
            end else begin
              state_q <= IDLE;
              idx_q   <= 2'd0;
              vec_q   <= 2'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 3'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in1       = vec_q[1];
  assign in2       = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign fail_mask = fail_mask_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - scoreboard bench for gate_truth_checker
// Two instances (SETTLE=2 and SETTLE=1) each drive a modelled gate; a monitor pops expectations on done.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode = 0;

  logic       start_a = 1'b0, abort_a = 1'b0, in1_a, in2_a, out_a, busy_a, done_a, pass_a;
  logic [3:0] result_a, fail_mask_a;
  logic [2:0] err_cnt_a;
  logic       start_b = 1'b0, abort_b = 1'b0, in1_b, in2_b, out_b, busy_b, done_b, pass_b;
  logic [3:0] result_b, fail_mask_b;
  logic [2:0] err_cnt_b;

  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return a | b;
      default: return 1'b0;
    endcase
  endfunction

  assign out_a = gate(mode, in1_a, in2_a);
  assign out_b = gate(mode, in1_b, in2_b);

  gate_truth_checker #(.EXPECT(4'b1000), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .in1(in1_a), .in2(in2_a), .out(out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .result(result_a), .fail_mask(fail_mask_a), .err_cnt(err_cnt_a)
  );

  gate_truth_checker #(.EXPECT(4'b1000), .SETTLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .in1(in1_b), .in2(in2_b), .out(out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .result(result_b), .fail_mask(fail_mask_b), .err_cnt(err_cnt_b)
  );

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] fm;
    logic [2:0] ec;
    logic       ps;
    logic [7:0] lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  int cyc = 0;
  int t0_a = 0, t0_b = 0;
  logic busy_pa = 1'b0, done_pa = 1'b0, busy_pb = 1'b0, done_pb = 1'b0;
  logic [15:0] seq_a = 16'd0;
  logic [15:0] seq_b = 16'd0;

  // Monitor: records drive sequence while busy and scores each rising done.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (busy_a && !busy_pa) t0_a = cyc;
      if (busy_a) seq_a = {seq_a[13:0], in1_a, in2_a};
      if (done_a && !done_pa) begin
        chk("a_queue_nonempty", int'(q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          chk("a_result", result_a, e.res);
          chk("a_fail_mask", fail_mask_a, e.fm);
          chk("a_err_cnt", err_cnt_a, e.ec);
          chk("a_pass", pass_a, e.ps);
          chk("a_latency", cyc - t0_a, e.lat);
        end
      end
      if (busy_b && !busy_pb) t0_b = cyc;
      if (busy_b) seq_b = {seq_b[13:0], in1_b, in2_b};
      if (done_b && !done_pb) begin
        chk("b_queue_nonempty", int'(q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          chk("b_result", result_b, e.res);
          chk("b_fail_mask", fail_mask_b, e.fm);
          chk("b_err_cnt", err_cnt_b, e.ec);
          chk("b_pass", pass_b, e.ps);
          chk("b_latency", cyc - t0_b, e.lat);
        end
      end
    end
    busy_pa = busy_a; done_pa = done_a;
    busy_pb = busy_b; done_pb = done_b;
  end

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (!(done_a && !busy_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_a, 1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_result"}, result_a, 0);
    chk({tag, "_fail_mask"}, fail_mask_a, 0);
    chk({tag, "_err_cnt"}, err_cnt_a, 0);
    chk({tag, "_vec"}, {in1_a, in2_a}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_a("rst");
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_done", done_b, 0);
    rst_n = 1'b1;

    // AND gate matches EXPECT
    mode = 0;
    q_a.push_back('{res: 4'b1000, fm: 4'b0000, ec: 3'd0, ps: 1'b1, lat: 8'd8});
    pulse_start_a();
    wait_done_a("t1_done");
    chk("t1_sequence", seq_a, 16'h05AF);

    // OR gate against AND expectation
    mode = 1;
    q_a.push_back('{res: 4'b1110, fm: 4'b0110, ec: 3'd2, ps: 1'b0, lat: 8'd8});
    pulse_start_a();
    wait_done_a("t2_done");

    // out stuck at 0, then restart with AND
    mode = 2;
    q_a.push_back('{res: 4'b0000, fm: 4'b1000, ec: 3'd1, ps: 1'b0, lat: 8'd8});
    pulse_start_a();
    wait_done_a("t3_done");
    mode = 0;
    q_a.push_back('{res: 4'b1000, fm: 4'b0000, ec: 3'd0, ps: 1'b1, lat: 8'd8});
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("t3_restart_done_low", done_a, 0);
    chk("t3_restart_busy", busy_a, 1);
    chk("t3_restart_result", result_a, 0);
    chk("t3_restart_fail_mask", fail_mask_a, 0);
    chk("t3_restart_err_cnt", err_cnt_a, 0);
    wait_done_a("t3b_done");

    // start re-pulsed while busy is ignored
    q_a.push_back('{res: 4'b1000, fm: 4'b0000, ec: 3'd0, ps: 1'b1, lat: 8'd8});
    pulse_start_a();
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_done_a("t4_done");

    // abort in IDLE clears done/pass
    @(negedge clk) abort_a = 1'b1;
    @(negedge clk) abort_a = 1'b0;
    chk("t4_idle_abort_done", done_a, 0);
    chk("t4_idle_abort_pass", pass_a, 0);

    // abort at +5 keeps bits 0,1 of an OR sweep
    mode = 1;
    pulse_start_a();
    repeat (4) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk) abort_a = 1'b0;
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_vec", {in1_a, in2_a}, 0);
    chk("t5_result", result_a, 4'b0010);
    chk("t5_fail_mask", fail_mask_a, 4'b0010);
    chk("t5_err_cnt", err_cnt_a, 1);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("t5_both_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    chk("t5_both_busy_later", busy_a, 0);
    chk("t5_both_done", done_a, 0);

    // async reset mid-sweep, then a SETTLE=1 sweep
    mode = 0;
    pulse_start_a();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_a("t6_async");
    @(negedge clk) rst_n = 1'b1;
    chk_reset_a("t6_after");
    q_b.push_back('{res: 4'b1000, fm: 4'b0000, ec: 3'd0, ps: 1'b1, lat: 8'd4});
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    begin
      int n = 0;
      while (!(done_b && !busy_b) && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_b_done", done_b, 1);
    chk("t6_b_sequence", seq_b[7:0], 8'h1B);

    repeat (2) @(negedge clk);
    chk("end_q_a_empty", q_a.size(), 0);
    chk("end_q_b_empty", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
